iq_mag_squared: RTL and testbench

- Sequential magnitude-squared stage that computes I^2 + Q^2 from one signed complex sample.
- Sits directly upstream of the sequential square-root block: its mag_sq/out_valid/out_ready connect to that block's num/i_valid/o_ready. The pair produces |IQ| for the SDR envelope/AGC path.
- Uses a shift-add multiplier with one adder, reused for I^2 and then Q^2, to keep area small.

---
 rtl/iq_mag_pkg.sv | 16 +
 rtl/iq_abs.sv | 16 +
 rtl/iq_mag_squared.sv | 140 ++++++++++++++
 tb/tb_iq_mag_squared.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/iq_mag_pkg.sv
// Shared types and sizing helpers for the I^2 + Q^2 magnitude-squared stage.
package iq_mag_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQ_I = 2'd1,
        SQ_Q = 2'd2,
        DONE = 2'd3
    } mag_sq_state_t;

    // Bit-counter width for a W-bit operand; W >= 2 keeps this at least 1.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/iq_abs.sv
// Combinational two's-complement magnitude: signed W-bit in, unsigned W-bit out.
module iq_abs #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] data_i,
    output logic [W-1:0] mag_o
);

    localparam logic [W-1:0] One = {{(W-1){1'b0}}, 1'b1};

    // -2^(W-1) negates to itself, which reads correctly as 2^(W-1) unsigned.
    always_comb begin
        mag_o = data_i[W-1] ? (~data_i + One) : data_i;
    end

endmodule

// File: rtl/iq_mag_squared.sv
// Sequential I^2 + Q^2 using one shift-add accumulator, squaring |I| then |Q|.
module iq_mag_squared
    import iq_mag_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [W-1:0]   i_data,
    input  logic [W-1:0]   q_data,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [2*W-1:0] mag_sq,
    output logic           out_valid,
    input  logic           out_ready
);

    localparam int unsigned CW = cnt_width(W);
    localparam logic [CW-1:0] CntMax = CW'(W - 1);
    localparam logic [CW-1:0] CntOne = CW'(1);

    mag_sq_state_t  state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [W-1:0]   abs_i_q, abs_i_d;
    logic [W-1:0]   abs_q_q, abs_q_d;
    logic [2*W-1:0] mag_q, mag_d;
    logic           out_valid_q, out_valid_d;
    logic           in_ready_q, in_ready_d;

    logic [W-1:0]   abs_i, abs_q;
    logic [W-1:0]   operand;
    logic [2*W-1:0] addend;
    logic [2*W-1:0] acc_sum;

    iq_abs #(.W(W)) u_abs_i (
        .data_i (i_data),
        .mag_o  (abs_i)
    );

    iq_abs #(.W(W)) u_abs_q (
        .data_i (q_data),
        .mag_o  (abs_q)
    );

    // Shared datapath: the one adder serves whichever operand is being squared.
    always_comb begin
        operand = (state_q == SQ_Q) ? abs_q_q : abs_i_q;
        addend  = '0;
        if (operand[cnt_q]) begin
            addend = {{W{1'b0}}, operand} << cnt_q;
        end
        acc_sum = acc_q + addend;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        abs_i_d     = abs_i_q;
        abs_q_d     = abs_q_q;
        mag_d       = mag_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;

        case (state_q)
            IDLE: begin
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                if (in_valid && in_ready_q) begin
                    abs_i_d    = abs_i;
                    abs_q_d    = abs_q;
                    acc_d      = '0;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = SQ_I;
                end
            end
            SQ_I: begin
                acc_d = acc_sum;
                if (cnt_q == CntMax) begin
                    cnt_d   = '0;
                    state_d = SQ_Q;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            SQ_Q: begin
                acc_d = acc_sum;
                if (cnt_q == CntMax) begin
                    cnt_d       = '0;
                    mag_d       = acc_sum;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            DONE: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            abs_i_q     <= '0;
            abs_q_q     <= '0;
            mag_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            abs_i_q     <= abs_i_d;
            abs_q_q     <= abs_q_d;
            mag_q       <= mag_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign mag_sq    = mag_q;

endmodule

// File: tb/tb_iq_mag_squared.sv
// Directed self-checking bench for iq_mag_squared with a floor-sqrt model downstream.
module tb_iq_mag_squared;

    localparam int unsigned W = 8;

    logic           clk;
    logic           reset_n;
    logic [W-1:0]   i_data;
    logic [W-1:0]   q_data;
    logic           in_valid;
    logic           in_ready;
    logic [2*W-1:0] mag_sq;
    logic           out_valid;
    logic           out_ready;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    iq_mag_squared #(.W(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_data    (i_data),
        .q_data    (q_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mag_sq    (mag_sq),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int isqrt(input int n);
        int r = 0;
        while ((r + 1) * (r + 1) <= n) r++;
        return r;
    endfunction

    // Sends one sample with out_ready high; checks latency, result and return to IDLE.
    task automatic do_sample(input string tag, input int i, input int q, input int exp,
                             output int res);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check({tag, " ready"}, 32'(in_ready), 32'd1);
        i_data   = W'(i);
        q_data   = W'(q);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, " in_ready@E0"}, 32'(in_ready), 32'd0);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'(2 * W));
        check({tag, " mag_sq"}, 32'(mag_sq), 32'(exp));
        res = int'(mag_sq);
        tick();
        check({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
        check({tag, " in_ready rise"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int res;
        int n;
        int idx;
        int got;
        int prev_rdy;
        int ti[3];
        int tq[3];
        int texp[3];
        int tmag[3];
        int tcyc[3];

        reset_n   = 1'b0;
        i_data    = '0;
        q_data    = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check("reset in_ready", 32'(in_ready), 32'd0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset mag_sq", 32'(mag_sq), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        check("in_ready before edge", 32'(in_ready), 32'd0);
        tick();
        check("in_ready after release", 32'(in_ready), 32'd1);

        do_sample("basic", 3, 4, 25, res);
        do_sample("min_min", -128, -128, 32768, res);
        do_sample("max_min", 127, -128, 32513, res);
        do_sample("zero", 0, 0, 0, res);

        // Backpressure: result held while out_ready low, new samples ignored.
        out_ready = 1'b0;
        i_data    = W'(3);
        q_data    = W'(4);
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        check("bp latency", 32'(n), 32'(2 * W));
        i_data   = W'(9);
        q_data   = W'(9);
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp out_valid held", 32'(out_valid), 32'd1);
            check("bp mag_sq held", 32'(mag_sq), 32'd25);
            check("bp in_ready low", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp out_valid drop", 32'(out_valid), 32'd0);
        check("bp in_ready rise", 32'(in_ready), 32'd1);
        check("bp mag_sq kept", 32'(mag_sq), 32'd25);

        // Throughput: back-to-back samples with in_valid held high.
        ti   = '{1, 2, -5};
        tq   = '{1, -2, 12};
        texp = '{2, 8, 169};
        idx  = 0;
        got  = 0;
        i_data   = W'(ti[0]);
        q_data   = W'(tq[0]);
        in_valid = 1'b1;
        prev_rdy = int'(in_ready);
        n = 0;
        while (got < 3 && n < 100) begin
            tick();
            n++;
            if (out_valid) begin
                tmag[got] = int'(mag_sq);
                tcyc[got] = cyc;
                got++;
            end
            if (prev_rdy == 1 && !in_ready) begin
                idx++;
                if (idx < 3) begin
                    i_data = W'(ti[idx]);
                    q_data = W'(tq[idx]);
                end else begin
                    in_valid = 1'b0;
                end
            end
            prev_rdy = int'(in_ready);
        end
        in_valid = 1'b0;
        check("tp count", 32'(got), 32'd3);
        for (int k = 0; k < 3; k++) begin
            if (k < got) check("tp mag_sq", 32'(tmag[k]), 32'(texp[k]));
        end
        if (got == 3) begin
            check("tp spacing 0-1", 32'(tcyc[1] - tcyc[0]), 32'(2 * W + 2));
            check("tp spacing 1-2", 32'(tcyc[2] - tcyc[1]), 32'(2 * W + 2));
        end
        tick();

        // Reset in the middle of SQ_Q.
        i_data   = W'(100);
        q_data   = W'(50);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("rst accepted", 32'(in_ready), 32'd0);
        for (int k = 0; k < W + 2; k++) tick();
        reset_n = 1'b0;
        #1;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd0);
        check("rst mag_sq", 32'(mag_sq), 32'd0);
        tick();
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        n = 0;
        for (int k = 0; k < 3 * W; k++) begin
            tick();
            if (out_valid) n++;
        end
        check("rst no stray out_valid", 32'(n), 32'd0);
        do_sample("post_rst", -7, -24, 625, res);

        // Downstream sqrt model on the produced magnitudes.
        do_sample("sqrt_a", 3, 4, 25, res);
        check("sqrt 3,4", 32'(isqrt(res)), 32'd5);
        do_sample("sqrt_b", -128, -128, 32768, res);
        check("sqrt -128,-128", 32'(isqrt(res)), 32'd181);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
